// File: rtl/arvi_pkg.sv
// arvi_pkg: types and constants shared by the decode stage and its decoder.
//   ctrl_t       - control bundle handed from decode to execute
//   dec_state_t  - decode-stage intake state (RUN / WFI_WAIT)
//   OP_*         - major opcodes (instr[6:0])
//   CAUSE_*      - exception cause codes reported alongside an entry
package arvi_pkg;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_op;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic       reg_write;
        logic [1:0] jump;
        logic       pc_plus4;
        logic       csr_en;
        logic       mret;
        logic       alum_en;
        logic       atomic;
    } ctrl_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_WFI_WAIT = 1'b1
    } dec_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder with legality checks.
//   instr    in  32     instruction word
//   ctrl     out ctrl_t control bundle (all zero when ex = 1)
//   ex       out 1      instruction raises an exception
//   ex_cause out 4      2 = illegal, 3 = breakpoint, 11 = ECALL-M
//   is_wfi   out 1      legal WFI encoding
// Optional feature: ARVI_ATOMIC_EN enables LR.W / SC.W decoding; without it
// the AMO opcode is illegal and ctrl.atomic is never set.
module ctrl_decode
    import arvi_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        ex,
    output logic [3:0]  ex_cause,
    output logic        is_wfi
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] f12;
    logic [4:0]  rs1;
    logic [4:0]  rd;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign f12    = instr[31:20];
    assign rs1    = instr[19:15];
    assign rd     = instr[11:7];

    ctrl_t raw;
    logic  illegal;
    logic  ecall;
    logic  ebreak;
    logic  wfi;

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        ecall   = 1'b0;
        ebreak  = 1'b0;
        wfi     = 1'b0;
        case (opcode)
            OP_R: begin
                raw.alu_op    = 3'b010;
                raw.reg_write = 1'b1;
                if (f7 == 7'h20) begin
                    // only SUB and SRA have an alternate encoding
                    if (f3 != 3'b000 && f3 != 3'b101) illegal = 1'b1;
                end else if (f7 == 7'h01 && M_EXT != 0) begin
                    raw.alum_en = 1'b1;
                end else if (f7 != 7'h00) begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                raw.alu_op    = 3'b011;
                raw.alu_src_b = 1'b1;
                raw.reg_write = 1'b1;
                // shift-immediates reuse imm[11:5] as a funct7
                if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
                if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
            end
            OP_LOAD: begin
                raw.mem_read   = 1'b1;
                raw.mem_to_reg = 1'b1;
                raw.alu_src_b  = 1'b1;
                raw.reg_write  = 1'b1;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal = 1'b1;
            end
            OP_STORE: begin
                raw.mem_write = 1'b1;
                raw.alu_src_b = 1'b1;
                if (f3 > 3'd2) illegal = 1'b1;
            end
            OP_BRANCH: begin
                raw.branch = 1'b1;
                raw.alu_op = 3'b001;
                if (f3 == 3'd2 || f3 == 3'd3) illegal = 1'b1;
            end
            OP_LUI: begin
                raw.alu_src_a = 2'd2;
                raw.alu_src_b = 1'b1;
                raw.alu_op    = 3'b100;
                raw.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                raw.alu_src_a = 2'd1;
                raw.alu_src_b = 1'b1;
                raw.alu_op    = 3'b100;
                raw.reg_write = 1'b1;
            end
            OP_JAL: begin
                raw.jump      = 2'd1;
                raw.pc_plus4  = 1'b1;
                raw.reg_write = 1'b1;
            end
            OP_JALR: begin
                raw.alu_src_b = 1'b1;
                raw.alu_op    = 3'b100;
                raw.jump      = 2'd2;
                raw.pc_plus4  = 1'b1;
                raw.reg_write = 1'b1;
                if (f3 != 3'd0) illegal = 1'b1;
            end
            OP_FENCE: begin
                // executes as a NOP in this pipeline
            end
            OP_SYSTEM: begin
                if (f3 == 3'd0) begin
                    if (rs1 == 5'd0 && rd == 5'd0) begin
                        case (f12)
                            12'h000: ecall    = 1'b1;
                            12'h001: ebreak   = 1'b1;
                            12'h302: raw.mret = 1'b1;
                            12'h105: wfi      = 1'b1;
                            default: illegal  = 1'b1;
                        endcase
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (f3 == 3'd4) begin
                    illegal = 1'b1;
                end else begin
                    raw.reg_write = 1'b1;
                    raw.csr_en    = 1'b1;
                end
            end
`ifdef ARVI_ATOMIC_EN
            OP_AMO: begin
                // f7[6:2] = 00010 is LR.W, 00011 is SC.W
                if (f3 == 3'b010 && f7[6:3] == 4'b0001) begin
                    raw.mem_read   = 1'b1;
                    raw.mem_to_reg = 1'b1;
                    raw.reg_write  = 1'b1;
                    raw.atomic     = 1'b1;
                    raw.alu_op     = 3'b101;
                    raw.mem_write  = f7[2];
                end else begin
                    illegal = 1'b1;
                end
            end
`else
            OP_AMO: illegal = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
        // compressed / reserved quadrants are never legal here
        if (instr[1:0] != 2'b11) illegal = 1'b1;
    end

    always_comb begin
        ex       = illegal | ecall | ebreak;
        ex_cause = 4'd0;
        if (illegal)     ex_cause = CAUSE_ILLEGAL;
        else if (ebreak) ex_cause = CAUSE_BREAK;
        else if (ecall)  ex_cause = CAUSE_ECALL_M;
        // an excepting entry must have no architectural side effects
        ctrl   = ex ? '0 : raw;
        is_wfi = wfi & ~illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with an output FIFO and WFI hold.
//   i_clk, i_rstn          clock, synchronous active-low reset
//   i_instr, i_pc, i_valid fetch side; o_ready = stage accepts
//   i_flush                drop all buffered entries and any pending WFI
//   i_irq_pending          releases a WFI hold
//   o_valid, i_ready       execute side handshake on the FIFO head
//   o_ctrl, o_pc, o_instr, o_ex, o_ex_cause  head entry (zero when !o_valid)
//   o_dbg_state            current intake state
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; o_ready never depends on i_ready, and a presented head holds
// its value until it is consumed.
// Optional feature: ARVI_ATOMIC_EN (see ctrl_decode).
module decode_stage
    import arvi_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int M_EXT = 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic            i_irq_pending,
    output logic            o_valid,
    input  logic            i_ready,
    output ctrl_t           o_ctrl,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr,
    output logic            o_ex,
    output logic [3:0]      o_ex_cause,
    output dec_state_t      o_dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        ctrl_t           ctrl;
        logic            ex;
        logic [3:0]      cause;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    ctrl_t      dec_ctrl;
    logic       dec_ex;
    logic [3:0] dec_cause;
    logic       dec_is_wfi;

    ctrl_decode #(.M_EXT(M_EXT)) u_dec (
        .instr    (i_instr),
        .ctrl     (dec_ctrl),
        .ex       (dec_ex),
        .ex_cause (dec_cause),
        .is_wfi   (dec_is_wfi)
    );

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    dec_state_t       state;
    dec_state_t       state_nxt;
    logic             push;
    logic             pop;
    entry_t           head;

    assign o_ready = (count < CNT_FULL) && (state == ST_RUN) && !i_flush;
    assign o_valid = (count != '0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: every read is masked by o_valid
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ctrl: dec_ctrl, ex: dec_ex, cause: dec_cause,
                              pc: i_pc, instr: i_instr};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:      if (push && dec_is_wfi) state_nxt = ST_WFI_WAIT;
            ST_WFI_WAIT: if (i_irq_pending || i_flush) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        head = o_valid ? mem[rd_ptr] : '0;
    end

    assign o_ctrl      = head.ctrl;
    assign o_ex        = head.ex;
    assign o_ex_cause  = head.cause;
    assign o_pc        = head.pc;
    assign o_instr     = head.instr;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a scoreboard queue.
module tb_decode_stage;
    import arvi_pkg::*;

    localparam int EW = $bits(ctrl_t) + 1 + 4 + 32 + 32;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_valid;
    logic        o_ready;
    logic        i_flush;
    logic        i_irq_pending;
    logic        o_valid;
    logic        i_ready;
    ctrl_t       o_ctrl;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_ex;
    logic [3:0]  o_ex_cause;
    dec_state_t  o_dbg_state;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    decode_stage #(.XLEN(32), .DEPTH(2), .M_EXT(1)) dut (
        .i_clk         (clk),
        .i_rstn        (i_rstn),
        .i_instr       (i_instr),
        .i_pc          (i_pc),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_flush       (i_flush),
        .i_irq_pending (i_irq_pending),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_ctrl        (o_ctrl),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_ex          (o_ex),
        .o_ex_cause    (o_ex_cause),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // hand-written expected control bundles per instruction class
    function automatic ctrl_t cx(input string kind);
        ctrl_t c;
        c = '0;
        case (kind)
            "r":     begin c.alu_op = 3'b010; c.reg_write = 1'b1; end
            "m":     begin c.alu_op = 3'b010; c.reg_write = 1'b1; c.alum_en = 1'b1; end
            "i":     begin c.alu_op = 3'b011; c.alu_src_b = 1'b1; c.reg_write = 1'b1; end
            "ld":    begin c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src_b = 1'b1; c.reg_write = 1'b1; end
            "st":    begin c.mem_write = 1'b1; c.alu_src_b = 1'b1; end
            "br":    begin c.branch = 1'b1; c.alu_op = 3'b001; end
            "lui":   begin c.alu_src_a = 2'd2; c.alu_src_b = 1'b1; c.alu_op = 3'b100; c.reg_write = 1'b1; end
            "auipc": begin c.alu_src_a = 2'd1; c.alu_src_b = 1'b1; c.alu_op = 3'b100; c.reg_write = 1'b1; end
            "jal":   begin c.jump = 2'd1; c.pc_plus4 = 1'b1; c.reg_write = 1'b1; end
            "jalr":  begin c.alu_src_b = 1'b1; c.alu_op = 3'b100; c.jump = 2'd2; c.pc_plus4 = 1'b1; c.reg_write = 1'b1; end
            "csr":   begin c.reg_write = 1'b1; c.csr_en = 1'b1; end
            "mret":  c.mret = 1'b1;
            "lr":    begin c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.atomic = 1'b1; c.alu_op = 3'b101; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // driver: offer one instruction, push its expected entry when accepted
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input ctrl_t c,
                        input logic ex, input logic [3:0] cause);
        bit done;
        done = 1'b0;
        i_instr = instr;
        i_pc    = pc;
        i_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (o_ready) begin
                exp_q.push_back({c, ex, cause, pc, instr});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %08h never accepted", instr);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (i_rstn && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got pc %08h instr %08h, expected none", o_pc, o_instr);
            end else if (i_ready) begin
                check("pop_entry", 128'({o_ctrl, o_ex, o_ex_cause, o_pc, o_instr}), 128'(exp_q.pop_front()));
            end else begin
                check("head_hold", 128'({o_ctrl, o_ex, o_ex_cause, o_pc, o_instr}), 128'(exp_q[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        i_rstn = 1'b0;
        i_instr = '0;
        i_pc = '0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_irq_pending = 1'b0;
        i_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 128'(o_valid), 128'd0);
        check("rst_ex", 128'({o_ex, o_ex_cause}), 128'd0);
        check("rst_ctrl", 128'(o_ctrl), 128'd0);
        check("rst_pc_instr", 128'({o_pc, o_instr}), 128'd0);
        @(posedge clk);
        #1;
        i_rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", 128'(o_ready), 128'd1);
        check("rst_state", 128'(o_dbg_state), 128'(ST_RUN));
        @(posedge clk);
        #1;

        // ADD latency: head visible the cycle after the push
        send(32'h00B50533, 32'h100, cx("r"), 1'b0, 4'd0);
        @(negedge clk);
        check("add_lat_valid", 128'(o_valid), 128'd1);
        check("add_lat_pc", 128'(o_pc), 128'h100);
        check("add_lat_ctrl", 128'({o_ctrl.reg_write, o_ctrl.alu_op, o_ex}), 128'({1'b1, 3'b010, 1'b0}));
        @(posedge clk);
        #1;

        // decode table, back to back
        send(32'h00000073, 32'h104, cx("nop"), 1'b1, 4'd11);  // ECALL
        send(32'h00100073, 32'h108, cx("nop"), 1'b1, 4'd3);   // EBREAK
        send(32'h30200073, 32'h10C, cx("mret"), 1'b0, 4'd0);  // MRET
        send(32'h00000000, 32'h110, cx("nop"), 1'b1, 4'd2);   // all zeros
        send(32'h40B51533, 32'h114, cx("nop"), 1'b1, 4'd2);   // f7=0x20, f3=001
        send(32'h40B50533, 32'h118, cx("r"), 1'b0, 4'd0);     // SUB
        send(32'h02B50533, 32'h11C, cx("m"), 1'b0, 4'd0);     // MUL
        send(32'h00150513, 32'h120, cx("i"), 1'b0, 4'd0);     // ADDI
        send(32'h40151513, 32'h124, cx("nop"), 1'b1, 4'd2);   // SLLI bad f7
        send(32'h0005A503, 32'h128, cx("ld"), 1'b0, 4'd0);    // LW
        send(32'h00A5A023, 32'h12C, cx("st"), 1'b0, 4'd0);    // SW
        send(32'h00B50063, 32'h130, cx("br"), 1'b0, 4'd0);    // BEQ
        send(32'h00B52063, 32'h134, cx("nop"), 1'b1, 4'd2);   // branch f3=2
        send(32'h12345537, 32'h138, cx("lui"), 1'b0, 4'd0);   // LUI
        send(32'h00000517, 32'h13C, cx("auipc"), 1'b0, 4'd0); // AUIPC
        send(32'h000000EF, 32'h140, cx("jal"), 1'b0, 4'd0);   // JAL
        send(32'h000500E7, 32'h144, cx("jalr"), 1'b0, 4'd0);  // JALR
        send(32'h30059573, 32'h148, cx("csr"), 1'b0, 4'd0);   // CSRRW
        send(32'h0FF0000F, 32'h14C, cx("nop"), 1'b0, 4'd0);   // FENCE
`ifdef ARVI_ATOMIC_EN
        send(32'h1005272F, 32'h150, cx("lr"), 1'b0, 4'd0);    // LR.W
`else
        send(32'h1005272F, 32'h150, cx("nop"), 1'b1, 4'd2);   // LR.W illegal
`endif
        drain();

        // WFI hold and release one cycle after the irq pulse
        send(32'h10500073, 32'h200, cx("nop"), 1'b0, 4'd0);
        @(negedge clk);
        check("wfi_ready_low", 128'(o_ready), 128'd0);
        check("wfi_state", 128'(o_dbg_state), 128'(ST_WFI_WAIT));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wfi_still_low", 128'(o_ready), 128'd0);
        @(posedge clk);
        #1;
        i_irq_pending = 1'b1;
        @(negedge clk);
        check("wfi_irq_cycle", 128'(o_ready), 128'd0);
        @(posedge clk);
        #1;
        i_irq_pending = 1'b0;
        @(negedge clk);
        check("wfi_release", 128'(o_ready), 128'd1);
        @(posedge clk);
        #1;

        // WFI pushed while irq already pending: exactly one WFI_WAIT cycle
        i_irq_pending = 1'b1;
        send(32'h10500073, 32'h204, cx("nop"), 1'b0, 4'd0);
        @(negedge clk);
        check("wfi_irq_same_low", 128'(o_ready), 128'd0);
        @(posedge clk);
        #1;
        i_irq_pending = 1'b0;
        @(negedge clk);
        check("wfi_irq_same_rel", 128'(o_ready), 128'd1);
        @(posedge clk);
        #1;
        drain();

        // full FIFO: third offer stalls, then everything pops in order
        i_ready = 1'b0;
        send(32'h00100093, 32'h300, cx("i"), 1'b0, 4'd0);
        send(32'h00200113, 32'h304, cx("i"), 1'b0, 4'd0);
        i_instr = 32'h00300193;
        i_pc = 32'h308;
        i_valid = 1'b1;
        @(negedge clk);
        check("full_ready", 128'(o_ready), 128'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("full_pop_ready", 128'(o_ready), 128'd0);
        send(32'h00300193, 32'h308, cx("i"), 1'b0, 4'd0);
        drain();

        // flush with full FIFO and a simultaneous offer
        i_ready = 1'b0;
        send(32'h00400213, 32'h400, cx("i"), 1'b0, 4'd0);
        send(32'h00500293, 32'h404, cx("i"), 1'b0, 4'd0);
        i_instr = 32'h00600313;
        i_pc = 32'h408;
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_valid", 128'(o_valid), 128'd0);
        check("flush_ready", 128'(o_ready), 128'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        send(32'h00700393, 32'h40C, cx("i"), 1'b0, 4'd0);
        drain();

        // reset in the middle of operation
        i_ready = 1'b0;
        send(32'h00800413, 32'h500, cx("i"), 1'b0, 4'd0);
        i_rstn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_valid", 128'(o_valid), 128'd0);
        check("mid_rst_head", 128'({o_ctrl, o_ex, o_ex_cause, o_pc, o_instr}), 128'd0);
        @(posedge clk);
        #1;
        i_rstn = 1'b1;
        i_ready = 1'b1;
        send(32'h00900493, 32'h504, cx("i"), 1'b0, 4'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
